// File: rtl/dma_desc_chain_fetch.sv
// Descriptor-chain fetch engine: walks a linked list of descriptors over an
// AXI4-Lite read master and queues complete descriptors in a prefetch FIFO.
module dma_desc_chain_fetch #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DESC_WORDS = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_DESC   = 256
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            top_ptr,
  input  logic [ADDR_W-1:0]            bot_ptr,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [1:0]                   err_code,
  output logic [15:0]                  desc_count,
  output logic [ADDR_W-1:0]            m_araddr,
  output logic [2:0]                   m_arprot,
  output logic                         m_arvalid,
  input  logic                         m_arready,
  input  logic [DATA_W-1:0]            m_rdata,
  input  logic [1:0]                   m_rresp,
  input  logic                         m_rvalid,
  output logic                         m_rready,
  output logic                         desc_valid,
  input  logic                         desc_ready,
  output logic [DESC_WORDS*DATA_W-1:0] desc_data,
  output logic                         desc_last
);

  localparam int unsigned DESC_W = DESC_WORDS * DATA_W;
  localparam int unsigned WIDX_W = $clog2(DESC_WORDS);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ENT_W  = DESC_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_PUSH, S_DRAIN, S_FLUSH
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d, bot_q, bot_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [DESC_W-1:0]   words_q, words_d;
  logic [15:0]         desc_count_q, desc_count_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                abort_pend_q, abort_pend_d;
  logic                busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic                m_arvalid_q, m_arvalid_d, m_rready_q, m_rready_d;
  logic [ADDR_W-1:0]   m_araddr_q, m_araddr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic                desc_valid_q, desc_valid_d;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];

  logic                fifo_push, fifo_flush, fifo_pop_c, fifo_full_c;
  logic                last_c, max_hit_c, bot_hit_c, ctrl_last_c, drained_c;
  logic [ADDR_W-1:0]   next_ptr_c;

  // Descriptor field decode and FIFO status
  assign next_ptr_c  = words_q[ADDR_W-1:0];
  assign ctrl_last_c = words_q[2*DATA_W];
  assign bot_hit_c   = (ptr_q == bot_q);
  assign max_hit_c   = ((desc_count_q + 16'd1) == 16'(MAX_DESC));
  assign last_c      = ctrl_last_c | bot_hit_c | max_hit_c;
  assign fifo_full_c = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_pop_c  = desc_valid_q & desc_ready;
  assign drained_c   = (fifo_cnt_q == '0) || ((fifo_cnt_q == CNT_W'(1)) && fifo_pop_c);

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    bot_d        = bot_q;
    widx_d       = widx_q;
    words_d      = words_q;
    desc_count_d = desc_count_q;
    err_code_d   = err_code_q;
    abort_pend_d = abort_pend_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;

    if (state_q != S_IDLE && abort) abort_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d        = top_ptr;
          bot_d        = bot_ptr;
          widx_d       = '0;
          desc_count_d = '0;
          err_code_d   = 2'd0;
          abort_pend_d = 1'b0;
          state_d      = S_AR;
        end
      end
      S_AR: begin
        if (m_arvalid_q && m_arready) state_d = S_R;
      end
      S_R: begin
        if (m_rready_q && m_rvalid) begin
          if (abort_pend_q || abort) begin
            state_d = S_FLUSH;
          end else if (m_rresp != 2'b00) begin
            error_d    = 1'b1;
            err_code_d = 2'd1;
            state_d    = S_FLUSH;
          end else begin
            for (int unsigned i = 0; i < DESC_WORDS; i++) begin
              if (widx_q == WIDX_W'(i)) words_d[i*DATA_W +: DATA_W] = m_rdata;
            end
            if (widx_q == WIDX_W'(DESC_WORDS - 1)) begin
              state_d = S_PUSH;
            end else begin
              widx_d  = widx_q + WIDX_W'(1);
              state_d = S_AR;
            end
          end
        end
      end
      S_PUSH: begin
        if (abort_pend_q) begin
          state_d = S_FLUSH;
        end else if (!fifo_full_c) begin
          fifo_push    = 1'b1;
          desc_count_d = desc_count_q + 16'd1;
          if (last_c) begin
            // Runaway guard: the descriptor is still delivered, but flagged.
            if (max_hit_c && !ctrl_last_c && !bot_hit_c) begin
              error_d    = 1'b1;
              err_code_d = 2'd3;
            end
            state_d = S_DRAIN;
          end else if (next_ptr_c[1:0] != 2'b00) begin
            error_d    = 1'b1;
            err_code_d = 2'd2;
            state_d    = S_FLUSH;
          end else begin
            ptr_d   = next_ptr_c;
            widx_d  = '0;
            state_d = S_AR;
          end
        end
      end
      S_DRAIN: begin
        if (abort_pend_q) begin
          state_d = S_FLUSH;
        end else if (drained_c) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        fifo_flush = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) abort_pend_d = 1'b0;

    // Outputs registered from next-state values so they line up with the state
    m_arvalid_d = (state_d == S_AR);
    m_araddr_d  = m_arvalid_d ? (ptr_d + (ADDR_W'(widx_d) << 2)) : m_araddr_q;
    m_rready_d  = (state_d == S_R);
    busy_d      = (state_d != S_IDLE);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end else begin
      if (fifo_push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (fifo_pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop_c);
    end
    desc_valid_d = (fifo_cnt_d != '0);
  end

  // Control and status registers with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      bot_q        <= '0;
      widx_q       <= '0;
      words_q      <= '0;
      desc_count_q <= '0;
      err_code_q   <= 2'd0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      m_arvalid_q  <= 1'b0;
      m_araddr_q   <= '0;
      m_rready_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      desc_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      bot_q        <= bot_d;
      widx_q       <= widx_d;
      words_q      <= words_d;
      desc_count_q <= desc_count_d;
      err_code_q   <= err_code_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      m_arvalid_q  <= m_arvalid_d;
      m_araddr_q   <= m_araddr_d;
      m_rready_q   <= m_rready_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      desc_valid_q <= desc_valid_d;
    end
  end

  // Prefetch FIFO storage; entries carry the last flag above the words
  always_ff @(posedge aclk) begin
    if (fifo_push) mem_q[wr_ptr_q] <= {last_c, words_q};
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;
  assign desc_count = desc_count_q;
  assign m_araddr   = m_araddr_q;
  assign m_arprot   = 3'b000;
  assign m_arvalid  = m_arvalid_q;
  assign m_rready   = m_rready_q;
  assign desc_valid = desc_valid_q;
  assign desc_data  = mem_q[rd_ptr_q][DESC_W-1:0];
  assign desc_last  = mem_q[rd_ptr_q][DESC_W];

endmodule

// File: tb/tb_dma_desc_chain_fetch.sv
// Bench for dma_desc_chain_fetch: memory-backed AXI-Lite slave, descriptor
// monitor, and a queue of expected descriptors per scenario.
`timescale 1ns/1ps
module tb_dma_desc_chain_fetch;

  typedef struct packed { logic last; logic [95:0] data; } exp_t;

  logic        aclk = 1'b0;
  logic        aresetn, start, abort;
  logic [31:0] top_ptr, bot_ptr;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [15:0] desc_count;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid, m_rready;
  logic        desc_valid, desc_ready;
  logic [95:0] desc_data;
  logic        desc_last;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:255];
  logic [31:0] err_addr;
  logic        ar_allow;
  exp_t        exp_q[$];
  int          obs_rd = 0;

  // Written only by the monitor / slave processes
  logic [95:0] obs_data [0:63];
  logic        obs_last [0:63];
  int          obs_n = 0, done_cnt = 0, done_busy_cnt = 0, err_cnt = 0;
  int          rd_cnt = 0, rd58_cnt = 0;
  logic        ar_hs, r_hs;
  logic [31:0] ar_a;

  always #5 aclk = ~aclk;

  dma_desc_chain_fetch #(
    .ADDR_W(32), .DATA_W(32), .DESC_WORDS(3), .FIFO_DEPTH(4), .MAX_DESC(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .top_ptr(top_ptr),
    .bot_ptr(bot_ptr), .abort(abort), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .desc_count(desc_count), .m_araddr(m_araddr),
    .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid),
    .m_rready(m_rready), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_data(desc_data), .desc_last(desc_last)
  );

  // AXI-Lite read slave: one beat returned the cycle after each AR handshake
  initial begin
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    forever begin
      @(negedge aclk);
      ar_hs = m_arvalid && m_arready;
      r_hs  = m_rvalid && m_rready;
      ar_a  = m_araddr;
      @(posedge aclk); #2;
      if (!aresetn) begin
        m_rvalid  = 1'b0;
        m_arready = 1'b0;
      end else begin
        if (r_hs) m_rvalid = 1'b0;
        if (ar_hs) begin
          rd_cnt = rd_cnt + 1;
          if (ar_a == 32'h58) rd58_cnt = rd58_cnt + 1;
          m_rvalid = 1'b1;
          m_rdata  = mem[ar_a[9:2]];
          m_rresp  = (ar_a == err_addr) ? 2'd2 : 2'd0;
        end
        m_arready = ar_allow;
      end
    end
  end

  // Record delivered descriptors and status pulses
  always @(negedge aclk) begin
    if (aresetn) begin
      if (desc_valid && desc_ready && obs_n < 64) begin
        obs_data[obs_n] <= desc_data;
        obs_last[obs_n] <= desc_last;
        obs_n <= obs_n + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (done && busy) done_busy_cnt <= done_busy_cnt + 1;
      if (error) err_cnt <= err_cnt + 1;
    end
  end

  task automatic set_desc(input logic [31:0] a, input logic [31:0] nxt,
                          input logic [31:0] bufa, input logic [31:0] ctrl);
    logic [7:0] i;
    i = a[9:2];
    mem[i] = nxt;
    mem[i + 8'd1] = bufa;
    mem[i + 8'd2] = ctrl;
  endtask

  function automatic exp_t mk_exp(input logic [31:0] a, input logic last);
    logic [7:0] i;
    exp_t e;
    i = a[9:2];
    e.last = last;
    e.data = {mem[i + 8'd2], mem[i + 8'd1], mem[i]};
    return e;
  endfunction

  task automatic run_start(input logic [31:0] top, input logic [31:0] bot);
    @(posedge aclk); #1;
    top_ptr = top; bot_ptr = bot; start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge aclk); #1;
      n++;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL %s_timeout busy=%b after %0d cycles", name, busy, budget);
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset;
    total++;
    if ({m_arvalid, m_rready, busy, done, error, desc_valid} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=000000",
                      {m_arvalid, m_rready, busy, done, error, desc_valid});
    end
    total++;
    if (m_araddr !== 32'h0 || m_arprot !== 3'b0) begin
      bad++; $display("FAIL reset_addr araddr=%h arprot=%b want 0", m_araddr, m_arprot);
    end
    total++;
    if (err_code !== 2'd0 || desc_count !== 16'd0) begin
      bad++; $display("FAIL reset_status err_code=%0d desc_count=%0d want 0", err_code, desc_count);
    end
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    total++;
    if (busy !== 1'b0 || m_arvalid !== 1'b0) begin
      bad++; $display("FAIL reset_release busy=%b arvalid=%b want 0", busy, m_arvalid);
    end
  endtask

  task automatic test_last_flag;
    exp_t e;
    int d0, e0, r0, r58;
    set_desc(32'h14, 32'h2c, 32'h1000, 32'h0);
    set_desc(32'h2c, 32'h40, 32'h2000, 32'h0);
    set_desc(32'h40, 32'h58, 32'h3000, 32'h1);
    set_desc(32'h58, 32'h14, 32'hdead, 32'h1);
    exp_q.push_back(mk_exp(32'h14, 1'b0));
    exp_q.push_back(mk_exp(32'h2c, 1'b0));
    exp_q.push_back(mk_exp(32'h40, 1'b1));
    desc_ready = 1'b1;
    d0 = done_cnt; e0 = err_cnt; r0 = rd_cnt; r58 = rd58_cnt;
    run_start(32'h14, 32'h58);
    total++;
    if (busy !== 1'b1 || m_arvalid !== 1'b1) begin
      bad++; $display("FAIL start_latency busy=%b arvalid=%b want 1 1", busy, m_arvalid);
    end
    total++;
    if (m_araddr !== 32'h14) begin
      bad++; $display("FAIL first_araddr got=%h want=00000014", m_araddr);
    end
    wait_idle(300, "last_flag");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_rd >= obs_n) begin
        bad++; $display("FAIL last_flag_desc missing want=%h last=%b", e.data, e.last);
      end else begin
        if ({obs_last[obs_rd], obs_data[obs_rd]} !== {e.last, e.data}) begin
          bad++; $display("FAIL last_flag_desc got=%h/%b want=%h/%b",
                          obs_data[obs_rd], obs_last[obs_rd], e.data, e.last);
        end
        obs_rd++;
      end
    end
    total++;
    if (desc_count !== 16'd3 || done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      bad++; $display("FAIL last_flag_status count=%0d done=%0d err=%0d want 3 1 0",
                      desc_count, done_cnt - d0, err_cnt - e0);
    end
    total++;
    if (rd58_cnt - r58 != 0 || rd_cnt - r0 != 9) begin
      bad++; $display("FAIL last_flag_reads at58=%0d reads=%0d want 0 9",
                      rd58_cnt - r58, rd_cnt - r0);
    end
  endtask

  task automatic test_bot_ptr;
    exp_t e;
    int d0, r0;
    set_desc(32'h40, 32'h58, 32'h3000, 32'h0);
    exp_q.push_back(mk_exp(32'h14, 1'b0));
    exp_q.push_back(mk_exp(32'h2c, 1'b1));
    d0 = done_cnt; r0 = rd_cnt;
    run_start(32'h14, 32'h2c);
    wait_idle(300, "bot_ptr");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_rd >= obs_n) begin
        bad++; $display("FAIL bot_ptr_desc missing want=%h last=%b", e.data, e.last);
      end else begin
        if ({obs_last[obs_rd], obs_data[obs_rd]} !== {e.last, e.data}) begin
          bad++; $display("FAIL bot_ptr_desc got=%h/%b want=%h/%b",
                          obs_data[obs_rd], obs_last[obs_rd], e.data, e.last);
        end
        obs_rd++;
      end
    end
    total++;
    if (desc_count !== 16'd2 || done_cnt - d0 != 1 || rd_cnt - r0 != 6) begin
      bad++; $display("FAIL bot_ptr_status count=%0d done=%0d reads=%0d want 2 1 6",
                      desc_count, done_cnt - d0, rd_cnt - r0);
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    int d0, r0;
    for (int i = 0; i < 6; i++) begin
      set_desc(32'h100 + 32'(i) * 32'h10, 32'h110 + 32'(i) * 32'h10,
               32'h5000 + 32'(i) * 32'h100, (i == 5) ? 32'h1 : 32'h0);
      exp_q.push_back(mk_exp(32'h100 + 32'(i) * 32'h10, i == 5));
    end
    desc_ready = 1'b0;
    d0 = done_cnt; r0 = rd_cnt;
    run_start(32'h100, 32'h3f0);
    repeat (80) @(posedge aclk);
    #1;
    total++;
    if (desc_count !== 16'd4 || desc_valid !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL stall_state count=%0d valid=%b busy=%b want 4 1 1",
                      desc_count, desc_valid, busy);
    end
    total++;
    if (m_arvalid !== 1'b0 || rd_cnt - r0 != 15 || obs_n != obs_rd) begin
      bad++; $display("FAIL stall_fetch arvalid=%b reads=%0d popped=%0d want 0 15 0",
                      m_arvalid, rd_cnt - r0, obs_n - obs_rd);
    end
    desc_ready = 1'b1;
    wait_idle(300, "backpressure");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_rd >= obs_n) begin
        bad++; $display("FAIL bp_desc missing want=%h last=%b", e.data, e.last);
      end else begin
        if ({obs_last[obs_rd], obs_data[obs_rd]} !== {e.last, e.data}) begin
          bad++; $display("FAIL bp_desc got=%h/%b want=%h/%b",
                          obs_data[obs_rd], obs_last[obs_rd], e.data, e.last);
        end
        obs_rd++;
      end
    end
    total++;
    if (desc_count !== 16'd6 || done_cnt - d0 != 1) begin
      bad++; $display("FAIL bp_status count=%0d done=%0d want 6 1", desc_count, done_cnt - d0);
    end
  endtask

  task automatic test_rresp_err;
    int d0, e0, o0;
    desc_ready = 1'b0;
    err_addr = 32'h30;
    d0 = done_cnt; e0 = err_cnt; o0 = obs_n;
    run_start(32'h14, 32'h58);
    wait_idle(300, "rresp");
    err_addr = 32'hffff_ffff;
    total++;
    if (err_cnt - e0 != 1 || err_code !== 2'd1) begin
      bad++; $display("FAIL rresp_err pulses=%0d code=%0d want 1 1", err_cnt - e0, err_code);
    end
    total++;
    if (desc_valid !== 1'b0 || done_cnt - d0 != 0 || desc_count !== 16'd1 || obs_n != o0) begin
      bad++; $display("FAIL rresp_flush valid=%b done=%0d count=%0d popped=%0d want 0 0 1 0",
                      desc_valid, done_cnt - d0, desc_count, obs_n - o0);
    end
  endtask

  task automatic test_max_desc;
    exp_t e;
    int d0, e0;
    set_desc(32'h200, 32'h200, 32'h7000, 32'h0);
    for (int i = 0; i < 8; i++) exp_q.push_back(mk_exp(32'h200, i == 7));
    desc_ready = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    run_start(32'h200, 32'h3fc);
    wait_idle(400, "max_desc");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_rd >= obs_n) begin
        bad++; $display("FAIL max_desc missing want=%h last=%b", e.data, e.last);
      end else begin
        if ({obs_last[obs_rd], obs_data[obs_rd]} !== {e.last, e.data}) begin
          bad++; $display("FAIL max_desc got=%h/%b want=%h/%b",
                          obs_data[obs_rd], obs_last[obs_rd], e.data, e.last);
        end
        obs_rd++;
      end
    end
    total++;
    if (obs_rd != obs_n) begin
      bad++; $display("FAIL max_desc_extra extra=%0d want 0", obs_n - obs_rd);
      obs_rd = obs_n;
    end
    total++;
    if (err_cnt - e0 != 1 || err_code !== 2'd3 || done_cnt - d0 != 1 || desc_count !== 16'd8) begin
      bad++; $display("FAIL max_desc_status err=%0d code=%0d done=%0d count=%0d want 1 3 1 8",
                      err_cnt - e0, err_code, done_cnt - d0, desc_count);
    end
  endtask

  task automatic test_misaligned;
    int d0, e0, r0;
    set_desc(32'h240, 32'h2e, 32'h8000, 32'h0);
    desc_ready = 1'b0;
    d0 = done_cnt; e0 = err_cnt; r0 = rd_cnt;
    run_start(32'h240, 32'h3fc);
    wait_idle(300, "misaligned");
    total++;
    if (err_cnt - e0 != 1 || err_code !== 2'd2 || done_cnt - d0 != 0) begin
      bad++; $display("FAIL misaligned err=%0d code=%0d done=%0d want 1 2 0",
                      err_cnt - e0, err_code, done_cnt - d0);
    end
    total++;
    if (desc_valid !== 1'b0 || desc_count !== 16'd1 || rd_cnt - r0 != 3) begin
      bad++; $display("FAIL misaligned_flush valid=%b count=%0d reads=%0d want 0 1 3",
                      desc_valid, desc_count, rd_cnt - r0);
    end
  endtask

  task automatic test_abort;
    int d0, e0, r0, o0;
    desc_ready = 1'b1;
    ar_allow = 1'b0;
    d0 = done_cnt; e0 = err_cnt; r0 = rd_cnt; o0 = obs_n;
    run_start(32'h14, 32'h58);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (m_arvalid !== 1'b1 || m_araddr !== 32'h14) begin
        bad++; $display("FAIL abort_hold cyc=%0d arvalid=%b araddr=%h want 1 00000014",
                        i, m_arvalid, m_araddr);
      end
      if (i < 2) begin @(posedge aclk); #1; end
    end
    abort = 1'b1;
    @(posedge aclk); #1;
    abort = 1'b0;
    ar_allow = 1'b1;
    total++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h14) begin
      bad++; $display("FAIL abort_hold_after arvalid=%b araddr=%h want 1 00000014",
                      m_arvalid, m_araddr);
    end
    wait_idle(100, "abort");
    total++;
    if (done_cnt - d0 != 0 || err_cnt - e0 != 0 || busy !== 1'b0 || desc_valid !== 1'b0) begin
      bad++; $display("FAIL abort_status done=%0d err=%0d busy=%b valid=%b want 0 0 0 0",
                      done_cnt - d0, err_cnt - e0, busy, desc_valid);
    end
    total++;
    if (rd_cnt - r0 != 1 || obs_n != o0) begin
      bad++; $display("FAIL abort_reads reads=%0d popped=%0d want 1 0", rd_cnt - r0, obs_n - o0);
    end
  endtask

  task automatic test_reset_midrun;
    ar_allow = 1'b0;
    run_start(32'h14, 32'h58);
    total++;
    if (m_arvalid !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL midrun_pre arvalid=%b busy=%b want 1 1", m_arvalid, busy);
    end
    aresetn = 1'b0;
    @(posedge aclk); #1;
    total++;
    if (m_arvalid !== 1'b0 || busy !== 1'b0 || m_araddr !== 32'h0 || desc_count !== 16'd0) begin
      bad++; $display("FAIL midrun_reset arvalid=%b busy=%b araddr=%h count=%0d want 0 0 0 0",
                      m_arvalid, busy, m_araddr, desc_count);
    end
    aresetn = 1'b1;
    ar_allow = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    total++;
    if (m_arvalid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL midrun_idle arvalid=%b busy=%b want 0 0", m_arvalid, busy);
    end
  endtask

  initial begin
    aresetn = 1'b0; start = 1'b0; abort = 1'b0; top_ptr = '0; bot_ptr = '0;
    desc_ready = 1'b0; ar_allow = 1'b1; err_addr = 32'hffff_ffff;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (3) @(posedge aclk);
    #1;
    test_reset;
    test_last_flag;
    test_bot_ptr;
    test_backpressure;
    test_rresp_err;
    test_max_desc;
    test_misaligned;
    test_abort;
    test_reset_midrun;
    total++;
    if (done_busy_cnt != 0) begin
      bad++; $display("FAIL done_with_busy count=%0d want 0", done_busy_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
